// File: rtl/aes_ctr_round_ctrl.sv
// rtl/aes_ctr_round_ctrl.sv - Iterative AES CTR-mode round sequencer
// Owns counter, state and round registers; one external round per cycle.
module aes_ctr_round_ctrl #(
    parameter int NR  = 14,
    parameter int RKW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           iv_load_i,
    input  logic [127:0]   iv_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [127:0]   in_data_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [127:0]   out_data_o,
    output logic [RKW-1:0] rk_idx_o,
    input  logic [127:0]   rk_i,
    output logic [127:0]   round_state_o,
    input  logic [127:0]   round_state_i,
    output logic           last_round_o,
    output logic           busy_o,
    output logic [127:0]   ctr_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);
    localparam logic [RKW-1:0] ONE        = RKW'(1);

    fsm_t           fsm_q;
    logic [RKW-1:0] round_q;
    logic [127:0]   ctr_q;
    logic [127:0]   state_q;
    logic [127:0]   data_q;
    logic [127:0]   out_data_q;
    logic           out_valid_q;
    logic           busy_q;
    logic           last_q;
    logic           accept;

    assign in_ready_o = ((fsm_q == IDLE) && !iv_load_i) || ((fsm_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // round_q is held at zero outside RUN, so it doubles as the key index
    assign rk_idx_o      = round_q;
    assign round_state_o = state_q;
    assign out_data_o    = out_data_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = busy_q;
    assign last_round_o  = last_q;
    assign ctr_o         = ctr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            ctr_q       <= '0;
            state_q     <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
        end else if (accept) begin
            fsm_q        <= RUN;
            state_q      <= ctr_q ^ rk_i;
            data_q       <= in_data_i;
            ctr_q[31:0]  <= ctr_q[31:0] + 32'd1;
            round_q      <= ONE;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
            last_q       <= (LAST_ROUND == ONE);
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (iv_load_i) begin
                        ctr_q <= iv_i;
                    end
                end
                RUN: begin
                    state_q <= round_state_i;
                    if (round_q == LAST_ROUND) begin
                        out_data_q  <= round_state_i ^ data_q;
                        round_q     <= '0;
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        last_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + ONE;
                        last_q  <= ((round_q + ONE) == LAST_ROUND);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ctr_round_ctrl.sv
// tb/tb_aes_ctr_round_ctrl.sv - Bench: behavioural AES round/key model plus CTR reference
// Drives AES-256 (NR=14) and AES-128 (NR=10) instances.
module tb_aes_ctr_round_ctrl;
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FIPS_IV = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_rst, a_iv_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
    logic [127:0] a_iv, a_in_data, a_out_data, a_rk, a_rs_o, a_rs_i, a_ctr;
    logic [3:0]   a_rk_idx;
    logic         b_rst, b_iv_load, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
    logic [127:0] b_iv, b_in_data, b_out_data, b_rk, b_rs_o, b_rs_i, b_ctr;
    logic [3:0]   b_rk_idx;

    logic [127:0] ctr_m, exp_m, d, held;
    logic [127:0] exp_q[$];
    int           cyc, nvalid;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, p, r, s;
        logic [7:0] e;
        inv = 8'h01; p = x; e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        r = inv; s = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ rk;
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int nr, input int r);
        logic [31:0] w [64];
        logic [31:0] tmp;
        logic [7:0]  rc;
        if (r > nr) return '0;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key, input int nk, input int nr);
        logic [127:0] s;
        s = pt ^ round_key(key, nk, nr, 0);
        for (int r = 1; r <= nr; r++) s = aes_round(s, round_key(key, nk, nr, r), r == nr);
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // External key store and combinational round datapath for each instance
    assign a_rk   = round_key(KEY256, 8, 14, int'(a_rk_idx));
    assign a_rs_i = aes_round(a_rs_o, a_rk, a_last);
    assign b_rk   = round_key(KEY128, 4, 10, int'(b_rk_idx));
    assign b_rs_i = aes_round(b_rs_o, b_rk, b_last);

    aes_ctr_round_ctrl #(.NR(14), .RKW(4)) u14 (
        .clk_i(clk), .rst_i(a_rst), .iv_load_i(a_iv_load), .iv_i(a_iv),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .rk_idx_o(a_rk_idx), .rk_i(a_rk), .round_state_o(a_rs_o), .round_state_i(a_rs_i),
        .last_round_o(a_last), .busy_o(a_busy), .ctr_o(a_ctr)
    );

    aes_ctr_round_ctrl #(.NR(10), .RKW(4)) u10 (
        .clk_i(clk), .rst_i(b_rst), .iv_load_i(b_iv_load), .iv_i(b_iv),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .rk_idx_o(b_rk_idx), .rk_i(b_rk), .round_state_o(b_rs_o), .round_state_i(b_rs_i),
        .last_round_o(b_last), .busy_o(b_busy), .ctr_o(b_ctr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [127:0] data);
        a_in_valid = 1'b1;
        a_in_data  = data;
        #1;
        chk1("accept_ready", a_in_ready, 1'b1);
        chk("accept_rk_idx", 128'(a_rk_idx), 128'd0);
        exp_m = aes_enc(ctr_m, KEY256, 8, 14) ^ data;
        ctr_m[31:0] = ctr_m[31:0] + 32'd1;
        step();
        a_in_valid = 1'b0;
        chk1("accept_busy", a_busy, 1'b1);
        chk("accept_ctr", a_ctr, ctr_m);
    endtask

    task automatic finish_block(input logic poke_iv);
        cyc = 1;
        while (!a_out_valid && cyc < 40) begin
            chk("run_rk_idx", 128'(a_rk_idx), 128'(cyc));
            chk1("run_last", a_last, cyc == 14);
            chk1("run_busy", a_busy, 1'b1);
            if (poke_iv) begin
                a_iv_load = 1'b1;
                a_iv      = rnd128();
            end
            step();
            if (poke_iv) chk("run_iv_ignored", a_ctr, ctr_m);
            cyc++;
        end
        a_iv_load = 1'b0;
        chk("latency", 128'(cyc), 128'd15);
        chk("out_data", a_out_data, exp_m);
        chk1("done_busy", a_busy, 1'b0);
    endtask

    task automatic handshake();
        a_out_ready = 1'b1;
        #1;
        chk1("hs_ready", a_in_ready, 1'b1);
        step();
        a_out_ready = 1'b0;
        chk1("hs_valid_drop", a_out_valid, 1'b0);
    endtask

    initial begin
        a_rst = 1'b1; a_iv_load = 1'b0; a_iv = '0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_iv_load = 1'b0; b_iv = '0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        ctr_m = '0;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        chk1("rst_out_valid", a_out_valid, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_last", a_last, 1'b0);
        chk("rst_rk_idx", 128'(a_rk_idx), 128'd0);
        chk("rst_ctr", a_ctr, 128'd0);
        chk("rst_out_data", a_out_data, 128'd0);
        chk("rst_state", a_rs_o, 128'd0);
        chk1("rst_in_ready", a_in_ready, 1'b1);

        // iv load collides with valid data: load wins, data taken next cycle
        a_iv_load = 1'b1; a_iv = FIPS_IV; a_in_valid = 1'b1; a_in_data = '0;
        #1;
        chk1("load_ready_low", a_in_ready, 1'b0);
        step();
        a_iv_load = 1'b0;
        ctr_m = FIPS_IV;
        chk1("load_not_accepted", a_busy, 1'b0);
        chk("load_ctr", a_ctr, FIPS_IV);
        start_block('0);
        finish_block(1'b0);
        chk("fips256", a_out_data, CT256);
        handshake();

        // 32-bit counter wrap, iv_load ignored during RUN, then back-pressure
        ctr_m = {rnd128() & {96{1'b1}}, 32'hffffffff};
        a_iv_load = 1'b1; a_iv = ctr_m;
        step();
        a_iv_load = 1'b0;
        start_block(rnd128());
        finish_block(1'b1);
        handshake();
        start_block(rnd128());
        chk("wrap_low_word", 128'(a_ctr[31:0]), 128'd1);
        finish_block(1'b0);
        held = exp_m;
        d = rnd128();
        a_in_valid = 1'b1; a_in_data = d; a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("bp_valid", a_out_valid, 1'b1);
            chk("bp_data", a_out_data, held);
            chk1("bp_ready", a_in_ready, 1'b0);
            step();
            chk1("bp_busy", a_busy, 1'b0);
        end
        a_out_ready = 1'b1;
        start_block(d);
        a_out_ready = 1'b0;
        chk1("bp_consumed", a_out_valid, 1'b0);
        finish_block(1'b0);
        handshake();

        // Streaming: accepts every 15 cycles with ready held high
        a_out_ready = 1'b1;
        for (int t = 0; t <= 60; t++) begin
            a_in_valid = (t <= 45);
            if (t % 15 == 0 && t <= 45) begin
                d = rnd128();
                a_in_data = d;
                exp_q.push_back(aes_enc(ctr_m, KEY256, 8, 14) ^ d);
                ctr_m[31:0] = ctr_m[31:0] + 32'd1;
            end
            #1;
            chk1("st_ready", a_in_ready, t % 15 == 0);
            chk1("st_busy", a_busy, t % 15 != 0);
            chk1("st_valid", a_out_valid, (t % 15 == 0) && t >= 15);
            if ((t % 15 == 0) && t >= 15 && exp_q.size() > 0) chk("st_data", a_out_data, exp_q.pop_front());
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        chk1("st_idle", a_out_valid, 1'b0);
        chk("st_ctr", a_ctr, ctr_m);

        // Reset in the middle of a block aborts it
        start_block(rnd128());
        for (int k = 0; k < 6; k++) step();
        chk("mid_round", 128'(a_rk_idx), 128'd7);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        ctr_m = '0;
        #1;
        chk1("abort_valid", a_out_valid, 1'b0);
        chk("abort_ctr", a_ctr, 128'd0);
        chk("abort_rk_idx", 128'(a_rk_idx), 128'd0);
        chk1("abort_busy", a_busy, 1'b0);
        chk1("abort_ready", a_in_ready, 1'b1);
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (a_out_valid) nvalid++;
        end
        chk("abort_no_output", 128'(nvalid), 128'd0);

        // NR=10 instance against the AES-128 known answer
        b_iv_load = 1'b1; b_iv = FIPS_IV;
        step();
        b_iv_load = 1'b0;
        b_in_valid = 1'b1; b_in_data = '0;
        #1;
        chk1("nr10_ready", b_in_ready, 1'b1);
        step();
        b_in_valid = 1'b0;
        cyc = 1;
        while (!b_out_valid && cyc < 40) begin
            chk("nr10_rk_idx", 128'(b_rk_idx), 128'(cyc));
            chk1("nr10_last", b_last, cyc == 10);
            step();
            cyc++;
        end
        chk("nr10_latency", 128'(cyc), 128'd11);
        chk("nr10_fips128", b_out_data, CT128);
        chk("nr10_model", b_out_data, aes_enc(FIPS_IV, KEY128, 4, 10));
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        chk1("nr10_done", b_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/aes_ctr_round_ctrl.md
Name: aes_ctr_round_ctrl

Overview:
Iterative AES CTR-mode sequencer. It owns the counter block, the state register and the round counter. Each cycle it drives one round through an external combinational round datapath (subbytes, shiftrows, mixcolumn, addroundkey) and fetches round keys from the key-schedule store by index. It XORs the final keystream with the input data and presents ciphertext on a valid/ready stream.

Parameters:
NR, 14, number of rounds (14 for AES-256; 10 and 12 also legal)
RKW, 4, width of round-key index

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
iv_load_i  in  1  load initial counter block (honoured in IDLE only)
iv_i  in  128  initial counter block
in_valid_i  in  1  input data block valid
in_ready_o  out  1  input data block accepted when both in_valid_i and in_ready_o are high
in_data_i  in  128  plaintext/ciphertext block to XOR
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
out_data_o  out  128  in_data ^ keystream
rk_idx_o  out  RKW  round-key index to key store
rk_i  in  128  round key for rk_idx_o, combinational same cycle
round_state_o  out  128  state into round datapath
round_state_i  in  128  round datapath result, combinational same cycle
last_round_o  out  1  final round flag; datapath bypasses mixcolumn
busy_o  out  1  high in RUN
ctr_o  out  128  current counter block

Behaviour:
- States: IDLE, RUN, DONE. Round counter `round` is RKW bits wide.
- Reset: state IDLE; round, ctr, state register, data register, out_data_o = 0; out_valid_o = 0; busy_o = 0; last_round_o = 0; rk_idx_o = 0. Reset during any state aborts the block with no output.
- rk_idx_o: 0 in IDLE/DONE, `round` in RUN.
- round_state_o: state register.
- last_round_o = RUN && round == NR.
- in_ready_o = (IDLE && !iv_load_i) || (DONE && out_ready_i).
- IDLE with iv_load_i: ctr <= iv_i. Any in_valid_i in that cycle is not accepted.
- iv_load_i in RUN or DONE is ignored.
- Accept (in_valid_i && in_ready_o), action A:
  - state <= ctr ^ rk_i (initial addroundkey, rk_idx_o = 0)
  - data_reg <= in_data_i
  - ctr[31:0] <= ctr[31:0] + 1 mod 2^32; ctr[127:32] unchanged (wrap ffffffff -> 00000000, no carry)
  - round <= 1; go to RUN
- RUN:
  - state <= round_state_i; round <= round + 1
  - if round == NR: out_data_o <= round_state_i ^ data_reg; round <= 0; go to DONE
- DONE:
  - out_valid_o = 1; out_data_o held stable until the handshake
  - on out_ready_i: if in_valid_i, perform action A (back-to-back); else go to IDLE
- Latency: acceptance in cycle C0, rounds 1..NR in C1..CNR, out_valid_o high from C(NR+1).
- Sustained throughput: one block per NR+1 cycles.
- ctr_o is the counter register; it advances in the accept cycle, so it shows the value for the next block.
- Round datapath contract: round_state_i = round(round_state_o, rk_i, last_round_o), purely combinational, no registers.

Test Plan:
- FIPS-197 AES-256 round model with key 000102..1f, iv_i = 00112233445566778899aabbccddeeff, in_data_i = 0 -> out_data_o = 8ea2b7ca516745bfeafc49904b496089; out_valid_o first high 15 cycles after the accept cycle; rk_idx_o steps 0,1..14; last_round_o high only with rk_idx_o = 14.
- iv_i low word ffffffff, two blocks -> second keystream uses low word 00000000 with upper 96 bits unchanged; ctr_o after second accept has low word 00000001.
- out_ready_i held low 5 cycles in DONE while in_valid_i = 1 -> out_valid_o stays 1, out_data_o stable, in_ready_o = 0, nothing accepted; release -> new block accepted in the same cycle as the output handshake.
- Continuous in_valid_i and out_ready_i, 4 blocks -> accepts at cycles 0, 15, 30, 45; busy_o low only in accept/DONE cycles.
- iv_load_i and in_valid_i together in IDLE -> in_ready_o = 0 that cycle; block accepted next cycle using the new iv_i. iv_load_i during RUN -> ctr_o unchanged.
- rst_i asserted at round 7 -> next cycle IDLE, out_valid_o = 0, ctr_o = 0, rk_idx_o = 0; NR = 10 build -> out_valid_o 11 cycles after accept, last_round_o with rk_idx_o = 10.
